// File: rtl/aroc_ss_receiver_if.sv
// Link between the AROC serial-ID shifter / management logic and the receiver.
// The receiver drives the load strobe and the validated ID; the environment drives DATO.
interface aroc_ss_receiver_if #(
  parameter int FRAME_BITS = 4
);
  logic                  AROC_SS_DATO;
  logic                  AROC_SS_LD_N;
  logic [FRAME_BITS-1:0] ROC_ID;
  logic                  ROC_ID_VLD;
  logic                  ROC_ID_CHG;

  modport master (
    input  AROC_SS_DATO,
    output AROC_SS_LD_N, ROC_ID, ROC_ID_VLD, ROC_ID_CHG
  );

  modport slave (
    output AROC_SS_DATO,
    input  AROC_SS_LD_N, ROC_ID, ROC_ID_VLD, ROC_ID_CHG
  );
endinterface

// File: rtl/aroc_ss_receiver.sv
// Polls the AROC serial-ID shifter frame after frame, deserializes the ROC ID
// and only publishes it once STABLE_CNT consecutive frames agree.
module aroc_ss_receiver #(
  parameter int FRAME_BITS = 4,
  parameter int LOAD_CYC   = 2,
  parameter int IDLE_CYC   = 4,
  parameter int STABLE_CNT = 2
) (
  input  logic              AROC_SS_CLK,
  input  logic              PGD_AROC,
  aroc_ss_receiver_if.master bus
);
  localparam int CNT_MAX = (LOAD_CYC > FRAME_BITS) ?
                           ((LOAD_CYC > IDLE_CYC) ? LOAD_CYC : IDLE_CYC) :
                           ((FRAME_BITS > IDLE_CYC) ? FRAME_BITS : IDLE_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int MW = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {LOAD, SHIFT, COMPARE, IDLE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic                  ld_n, ld_n_nxt;
  logic [FRAME_BITS-1:0] sreg, cand, roc_id;
  logic [MW-1:0]         match_cnt;
  logic                  cmp_done, vld, chg, upd;

  always_ff @(posedge AROC_SS_CLK or negedge PGD_AROC) begin
    if (!PGD_AROC) state <= LOAD;
    else           state <= state_nxt;
  end

  always_comb begin
    last = 1'b1;
    unique case (state)
      LOAD:    last = (int'(cnt) == LOAD_CYC - 1);
      SHIFT:   last = (int'(cnt) == FRAME_BITS - 1);
      IDLE:    last = (int'(cnt) == IDLE_CYC - 1);
      default: last = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (last) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = COMPARE;
      COMPARE: state_nxt = (IDLE_CYC == 0) ? LOAD : IDLE;
      IDLE:    if (last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Strobe is derived from the next state so the pin comes straight off a flop.
  always_comb begin
    ld_n_nxt = (state_nxt != LOAD);
  end

  always_ff @(posedge AROC_SS_CLK or negedge PGD_AROC) begin
    if (!PGD_AROC) begin
      ld_n <= 1'b0;
      cnt  <= '0;
    end else begin
      ld_n <= ld_n_nxt;
      cnt  <= (state_nxt != state) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge AROC_SS_CLK or negedge PGD_AROC) begin
    if (!PGD_AROC) begin
      sreg      <= '0;
      cand      <= '0;
      match_cnt <= '0;
      cmp_done  <= 1'b0;
    end else begin
      cmp_done <= (state == COMPARE);
      if (state == SHIFT)
        sreg <= {sreg[FRAME_BITS-2:0], bus.AROC_SS_DATO};
      if (state == COMPARE) begin
        if (sreg == cand && match_cnt != '0) begin
          if (match_cnt != MW'(STABLE_CNT)) match_cnt <= match_cnt + MW'(1);
        end else begin
          cand      <= sreg;
          match_cnt <= MW'(1);
        end
      end
    end
  end

  // A candidate equal to the published ID never re-fires CHG.
  assign upd = cmp_done && (match_cnt == MW'(STABLE_CNT)) && (!vld || cand != roc_id);

  always_ff @(posedge AROC_SS_CLK or negedge PGD_AROC) begin
    if (!PGD_AROC) begin
      roc_id <= '0;
      vld    <= 1'b0;
      chg    <= 1'b0;
    end else begin
      chg <= upd;
      if (upd) begin
        roc_id <= cand;
        vld    <= 1'b1;
      end
    end
  end

  assign bus.AROC_SS_LD_N = ld_n;
  assign bus.ROC_ID       = roc_id;
  assign bus.ROC_ID_VLD   = vld;
  assign bus.ROC_ID_CHG   = chg;
endmodule

// File: tb/tb_aroc_ss_receiver.sv
// Bench: two receivers (STABLE_CNT=2 and 1) behind shifter models; CHG pulses
// are checked by monitors against queued expected IDs.
module tb_aroc_ss_receiver;
  logic       clk;
  logic       pgd;
  logic [3:0] id;
  logic       tog, tog_en;
  logic [3:0] sh_a, sh_b;
  logic       prev_a, prev_b;
  int         errors, checks;
  int         qa[$], qb[$];

  aroc_ss_receiver_if #(.FRAME_BITS(4)) ifa ();
  aroc_ss_receiver_if #(.FRAME_BITS(4)) ifb ();

  aroc_ss_receiver #(.FRAME_BITS(4), .LOAD_CYC(2), .IDLE_CYC(4), .STABLE_CNT(2)) dut_a (
    .AROC_SS_CLK(clk), .PGD_AROC(pgd), .bus(ifa.master));
  aroc_ss_receiver #(.FRAME_BITS(4), .LOAD_CYC(2), .IDLE_CYC(4), .STABLE_CNT(1)) dut_b (
    .AROC_SS_CLK(clk), .PGD_AROC(pgd), .bus(ifb.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shifter models: parallel load while LD_N low, MSB-first shift otherwise.
  always @(posedge clk) begin
    if (!ifa.AROC_SS_LD_N) sh_a <= id; else sh_a <= {sh_a[2:0], 1'b0};
    if (!ifb.AROC_SS_LD_N) sh_b <= id; else sh_b <= {sh_b[2:0], 1'b0};
  end
  assign ifa.AROC_SS_DATO = tog_en ? tog : sh_a[3];
  assign ifb.AROC_SS_DATO = tog_en ? tog : sh_b[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: each CHG pulse consumes one expected ID.
  initial begin
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.ROC_ID_CHG) begin
        chk("a_chg_width", prev_a, 0);
        if (qa.size() == 0) chk("a_chg_extra", ifa.ROC_ID_CHG, 0);
        else begin
          chk("a_chg_id", ifa.ROC_ID, qa.pop_front());
          chk("a_chg_vld", ifa.ROC_ID_VLD, 1);
        end
      end
      if (ifb.ROC_ID_CHG) begin
        chk("b_chg_width", prev_b, 0);
        if (qb.size() == 0) chk("b_chg_extra", ifb.ROC_ID_CHG, 0);
        else begin
          chk("b_chg_id", ifb.ROC_ID, qb.pop_front());
          chk("b_chg_vld", ifb.ROC_ID_VLD, 1);
        end
      end
      prev_a = ifa.ROC_ID_CHG;
      prev_b = ifb.ROC_ID_CHG;
    end
  end

  // Entered at a negedge in the first LOAD cycle; returns at the next one.
  task automatic do_frame(input logic [3:0] v, input int ar, input int av, input int ac,
                          input int br, input int bc);
    int lo, hi, n;
    id = v;
    if (ac != 0) qa.push_back(ar);
    if (bc != 0) qb.push_back(br);
    lo = 0; hi = 0; n = 0;
    while (ifa.AROC_SS_LD_N == 1'b0 && n < 30) begin lo++; n++; @(negedge clk); end
    while (ifa.AROC_SS_LD_N == 1'b1 && n < 30) begin hi++; n++; @(negedge clk); end
    chk("ld_low_cycles", lo, 2);
    chk("ld_high_cycles", hi, 9);
    chk("a_roc_id", ifa.ROC_ID, ar);
    chk("a_vld", ifa.ROC_ID_VLD, av);
    chk("b_roc_id", ifb.ROC_ID, br);
    chk("b_vld", ifb.ROC_ID_VLD, 1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ld_n_a"}, ifa.AROC_SS_LD_N, 0);
    chk({nm, "_id_a"}, ifa.ROC_ID, 0);
    chk({nm, "_vld_a"}, ifa.ROC_ID_VLD, 0);
    chk({nm, "_chg_a"}, ifa.ROC_ID_CHG, 0);
    chk({nm, "_vld_b"}, ifb.ROC_ID_VLD, 0);
    chk({nm, "_id_b"}, ifb.ROC_ID, 0);
  endtask

  initial begin
    int n;
    errors = 0; checks = 0;
    pgd = 1'b0; id = 4'h9; tog = 1'b0; tog_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tog = ~tog;
      chk_reset("rst_hold");
    end
    tog_en = 1'b0;
    @(negedge clk);
    pgd = 1'b1;

    //        id    A:id vld chg  B:id chg
    do_frame(4'h9, 0,   0,  0,   9,   1);
    do_frame(4'h9, 9,   1,  1,   9,   0);
    do_frame(4'h9, 9,   1,  0,   9,   0);
    do_frame(4'hB, 9,   1,  0,   11,  1);
    do_frame(4'h9, 9,   1,  0,   9,   1);
    do_frame(4'h9, 9,   1,  0,   9,   0);
    do_frame(4'h6, 9,   1,  0,   6,   1);
    do_frame(4'h6, 6,   1,  1,   6,   0);
    do_frame(4'h6, 6,   1,  0,   6,   0);

    // Abort a frame after its second bit sample.
    n = 0;
    while (ifa.AROC_SS_LD_N == 1'b0 && n < 30) begin n++; @(negedge clk); end
    chk("shift_reached", ifa.AROC_SS_LD_N, 1);
    @(posedge clk);
    @(posedge clk);
    #1 pgd = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    chk_reset("rst_mid_hold");
    pgd = 1'b1;

    do_frame(4'h6, 0,   0,  0,   6,   1);
    do_frame(4'h6, 6,   1,  1,   6,   0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aroc_ss_receiver.md
Name: aroc_ss_receiver

Overview:
- Downstream consumer of the AROC serial-ID shifter. It drives the shifter's load strobe, deserializes the AROC_SS_DATO stream back into the 4-bit ROC ID, and debounces it across repeated frames.
- It presents a stable, validated ROC_ID to the CPLD management logic, plus a one-cycle change pulse.
- It runs continuously, polling frame after frame, while power-good is asserted.

Parameters:
- FRAME_BITS, 4: bits per serial frame; equals the ROC_ID width.
- LOAD_CYC, 2: cycles AROC_SS_LD_N is held low per frame (min 1).
- IDLE_CYC, 4: gap cycles between frame end and the next load (min 0).
- STABLE_CNT, 2: consecutive identical frames required before ROC_ID updates (min 1).

Ports:
- AROC_SS_CLK  in  1  system and shift clock, rising-edge.
- PGD_AROC  in  1  reset, asynchronous, active-low (power-good).
- AROC_SS_DATO  in  1  serial data from the shifter; MSB first.
- AROC_SS_LD_N  out  1  shifter parallel-load strobe, active-low, registered.
- ROC_ID  out  FRAME_BITS  debounced ID; bit 3 = ROC_ID_3 ... bit 0 = ROC_ID_0.
- ROC_ID_VLD  out  1  high once ROC_ID has been validated at least once since reset.
- ROC_ID_CHG  out  1  one-cycle pulse when ROC_ID takes a new value (including the first validation).

Behaviour:
- Reset (PGD_AROC=0, async): state=LOAD, AROC_SS_LD_N=0, ROC_ID=0, ROC_ID_VLD=0, ROC_ID_CHG=0, shift reg=0, candidate=0, match_cnt=0, all counters=0.
- Upstream contract: the shifter loads its parallel inputs while LD_N=0. While LD_N=1, DATO presents the current bit, and each rising edge advances to the next bit (order ID[3], ID[2], ID[1], ID[0]).
- State LOAD: AROC_SS_LD_N=0 for exactly LOAD_CYC cycles, then go to SHIFT.
- State SHIFT: AROC_SS_LD_N=1.
  - On each rising edge, sreg <= {sreg[FRAME_BITS-2:0], AROC_SS_DATO}.
  - After exactly FRAME_BITS samples, go to COMPARE.
  - The first sample occurs on the first edge with LD_N=1.
- State COMPARE: 1 cycle, AROC_SS_LD_N=1.
  - If sreg==candidate and match_cnt!=0: match_cnt <= min(match_cnt+1, STABLE_CNT).
  - Otherwise: candidate <= sreg, match_cnt <= 1.
  - Go to IDLE, or to LOAD if IDLE_CYC=0.
- Update rule: evaluated combinationally on the post-COMPARE match_cnt and registered one cycle after COMPARE.
  - If match_cnt==STABLE_CNT and (ROC_ID_VLD==0 or candidate!=ROC_ID): ROC_ID <= candidate, ROC_ID_VLD <= 1, ROC_ID_CHG=1 for exactly one cycle.
  - Equal repeated frames produce no further CHG.
  - ROC_ID_VLD never deasserts except on reset.
- State IDLE: AROC_SS_LD_N=1 for IDLE_CYC cycles, then go to LOAD.
- Frame period = LOAD_CYC + FRAME_BITS + 1 + IDLE_CYC; with defaults this is 11 cycles.
- Latency:
  - With STABLE_CNT=1, ROC_ID updates 1 cycle after the first COMPARE following the change.
  - In general, the update follows the STABLE_CNT-th consecutive matching frame.
- A single mismatched frame resets match_cnt to 1 on the new value; ROC_ID holds its old value.
- Saturation: match_cnt must not wrap. Counter width is clog2(STABLE_CNT+1).
- Reset mid-operation aborts the current frame immediately. The first post-reset frame starts at LOAD, and nothing is retained.
- AROC_SS_LD_N must be glitch-free: it is driven directly from a flop, never decoded combinationally.

Test Plan:
- Reset hold: PGD_AROC=0 for 5 cycles with DATO toggling -> LD_N=0, ROC_ID=0, VLD=0, CHG=0 throughout.
- Frame timing with the bench shifter model: release reset -> LD_N low exactly 2 cycles, high 9, repeating with an 11-cycle period; 4 samples per frame.
- First ID: ROC_ID_3..0 = 1,0,0,1, STABLE_CNT=2 -> after the 2nd frame's COMPARE, ROC_ID=4'h9, VLD=1, CHG high for exactly one cycle; later identical frames produce no CHG.
- Glitch rejection: ID stable at 4'h9, one frame's DATO corrupted to 4'hB -> ROC_ID stays 9 and no CHG; the next two good frames (match_cnt=1, then 2) cause no CHG, because the candidate equals ROC_ID.
- Change: ID switched 4'h9 -> 4'h6 permanently -> ROC_ID=6 after the 2nd 6-frame, single CHG pulse, VLD stays 1.
- Reset mid-SHIFT: assert PGD_AROC low after the 2nd bit sample -> LD_N=0, VLD=0, ROC_ID=0 asynchronously. After release, re-validation takes a full 2 frames, with STABLE_CNT=1 variant checked for 1-frame latency.
